// File: rtl/retospect_lif_cell.sv
// Leaky-integrate-and-fire neuron cell with a serial config chain and a selectable decay tick.
// Define RETOSPECT_LIF_INHIB_EN for signed (inhibitory) dendrite weights.

module retospect_lif_dend #(
  parameter int W_BITS = 3,
  parameter int S_BITS = 12
) (
  input  logic                     en,
  input  logic [W_BITS-1:0]        w,
  output logic signed [S_BITS-1:0] term
);
`ifdef RETOSPECT_LIF_INHIB_EN
  assign term = en ? {{(S_BITS-W_BITS){w[W_BITS-1]}}, w} : '0;
`else
  assign term = en ? {{(S_BITS-W_BITS){1'b0}}, w} : '0;
`endif
endmodule

module retospect_lif_cell #(
  parameter int N_DEND   = 4,
  parameter int W_BITS   = 3,
  parameter int P_BITS   = 5,
  parameter int SEL_BITS = 3,
  parameter int R_BITS   = 2,
  parameter int CFG_LEN  = N_DEND*W_BITS + P_BITS + SEL_BITS + R_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_nn,
  input  logic                    config_en,
  input  logic                    bs_in,
  output logic                    bs_out,
  input  logic [2**SEL_BITS-1:0]  clockbus,
  input  logic [N_DEND-1:0]       dendrite,
  output logic                    axon,
  output logic [P_BITS-1:0]       potential
);
  // Wide enough for full potential plus every weight, with a sign bit.
  localparam int S_BITS = P_BITS + W_BITS + $clog2(N_DEND+1) + 1;
  localparam logic signed [S_BITS-1:0] P_MAX = {{(S_BITS-P_BITS){1'b0}}, {P_BITS{1'b1}}};

  typedef enum logic {INTEG, REFR} state_t;

  state_t                    state_q, state_d;
  logic [CFG_LEN-1:0]        cfg_q, cfg_d;
  logic [P_BITS-1:0]         pot_q, pot_d;
  logic                      axon_q, axon_d;
  logic [R_BITS-1:0]         cnt_q, cnt_d;

  logic [N_DEND-1:0][W_BITS-1:0] w;
  logic [P_BITS-1:0]         threshold;
  logic [SEL_BITS-1:0]       decay_sel;
  logic [R_BITS-1:0]         refrac_len;
  logic signed [S_BITS-1:0]  term [N_DEND];
  logic signed [S_BITS-1:0]  acc;
  logic [P_BITS-1:0]         base, nxt;

  // Chain vector is {w[0], .., w[N_DEND-1], threshold, decay_sel, refrac_len}; it shifts right.
  assign threshold  = cfg_q[R_BITS+SEL_BITS +: P_BITS];
  assign decay_sel  = cfg_q[R_BITS +: SEL_BITS];
  assign refrac_len = cfg_q[0 +: R_BITS];
  assign bs_out     = cfg_q[0];
  assign axon       = axon_q;
  assign potential  = pot_q;

  for (genvar i = 0; i < N_DEND; i++) begin : g_dend
    assign w[i] = cfg_q[CFG_LEN-1-i*W_BITS -: W_BITS];
    retospect_lif_dend #(.W_BITS(W_BITS), .S_BITS(S_BITS)) u_dend (
      .en   (dendrite[i]),
      .w    (w[i]),
      .term (term[i])
    );
  end

  // Halve first on a decay tick, then add every active dendrite, then clamp.
  always_comb begin
    base = clockbus[decay_sel] ? (pot_q >> 1) : pot_q;
    acc  = {{(S_BITS-P_BITS){1'b0}}, base};
    for (int i = 0; i < N_DEND; i++) acc = acc + term[i];
    if (acc < 0)          nxt = '0;
    else if (acc > P_MAX) nxt = {P_BITS{1'b1}};
    else                  nxt = acc[P_BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    pot_d   = pot_q;
    axon_d  = 1'b0;
    cnt_d   = cnt_q;
    if (reset_nn) begin
      state_d = INTEG;
      pot_d   = '0;
      cnt_d   = '0;
    end else if (config_en) begin
      cfg_d   = {bs_in, cfg_q[CFG_LEN-1:1]};
      state_d = INTEG;
      cnt_d   = '0;
    end else begin
      case (state_q)
        INTEG: begin
          if (threshold != '0 && nxt >= threshold) begin
            axon_d  = 1'b1;
            pot_d   = '0;
            cnt_d   = refrac_len;
            state_d = (refrac_len == '0) ? INTEG : REFR;
          end else begin
            pot_d = nxt;
          end
        end
        REFR: begin
          pot_d = '0;
          cnt_d = cnt_q - R_BITS'(1);
          if (cnt_q == R_BITS'(1)) state_d = INTEG;
        end
        default: state_d = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTEG;
      cfg_q   <= '0;
      pot_q   <= '0;
      axon_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pot_q   <= pot_d;
      axon_q  <= axon_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_retospect_lif_cell.sv
// Directed self-checking bench for retospect_lif_cell (default parameters).
// Builds with RETOSPECT_LIF_INHIB_EN also exercise the signed-weight cases.

module tb_retospect_lif_cell;
  localparam int CFG_LEN = 22;

  logic       clk = 1'b0;
  logic       reset, reset_nn, config_en, bs_in;
  logic       bs_out, axon;
  logic [7:0] clockbus;
  logic [3:0] dendrite;
  logic [4:0] potential;

  int n_chk = 0;
  int n_fail = 0;

  retospect_lif_cell dut (
    .clk       (clk),
    .reset     (reset),
    .reset_nn  (reset_nn),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .clockbus  (clockbus),
    .dendrite  (dendrite),
    .axon      (axon),
    .potential (potential)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nn_pulse();
    reset_nn = 1'b1;
    step();
    reset_nn = 1'b0;
  endtask

  // First bit shifted lands in refrac_len[0], so send the vector LSB first.
  task automatic load_cfg(input logic [2:0] w0, input logic [2:0] w1, input logic [2:0] w2,
                          input logic [2:0] w3, input logic [4:0] thr, input logic [2:0] sel,
                          input logic [1:0] rl);
    logic [CFG_LEN-1:0] v;
    v = {w0, w1, w2, w3, thr, sel, rl};
    config_en = 1'b1;
    for (int i = 0; i < CFG_LEN; i++) begin
      bs_in = v[i];
      step();
    end
    config_en = 1'b0;
    bs_in     = 1'b0;
  endtask

  initial begin
    logic [CFG_LEN-1:0] pat;
    reset = 1'b1; reset_nn = 1'b0; config_en = 1'b0; bs_in = 1'b0;
    clockbus = '0; dendrite = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_pot", potential, 0);
    chk("rst_axon", axon, 0);
    chk("rst_bs_out", bs_out, 0);

    // Basic integrate / fire / refractory
    load_cfg(3'd3, 0, 0, 0, 5'd7, 3'd0, 2'd2);
    nn_pulse();
    dendrite = 4'b0001;
    step(); chk("t1_pot3", potential, 3);
    step(); chk("t1_pot6", potential, 6);
    step(); chk("t1_fire_axon", axon, 1); chk("t1_fire_pot", potential, 0);
    step(); chk("t1_refr1_axon", axon, 0); chk("t1_refr1_pot", potential, 0);
    step(); chk("t1_refr2_axon", axon, 0); chk("t1_refr2_pot", potential, 0);
    step(); chk("t1_back_pot3", potential, 3); chk("t1_back_axon", axon, 0);
    // Equality with threshold fires
    dendrite = '0;
    load_cfg(3'd3, 0, 0, 0, 5'd6, 3'd0, 2'd0);
    nn_pulse();
    dendrite = 4'b0001;
    step(); chk("t1b_pot3", potential, 3);
    step(); chk("t1b_eq_axon", axon, 1); chk("t1b_eq_pot", potential, 0);
    dendrite = '0;

    // Simultaneous dendrites sum, then saturation reaches threshold 31
    load_cfg(3'd1, 3'd2, 3'd3, 3'd4, 5'd31, 3'd0, 2'd0);
    nn_pulse();
    dendrite = 4'b1111;
    step(); chk("t2_pot10", potential, 10);
    step(); chk("t2_pot20", potential, 20);
    step(); chk("t2_pot30", potential, 30); chk("t2_noax", axon, 0);
    step(); chk("t2_sat_fire", axon, 1); chk("t2_sat_pot", potential, 0);
    dendrite = '0;
    step(); chk("t2_pulse_one", axon, 0);

    // Decay from 12 via clockbus[1]
    load_cfg(3'd2, 0, 0, 0, 5'd0, 3'd1, 2'd0);
    nn_pulse();
    dendrite = 4'b0001;
    repeat (6) step();
    chk("t3_build12", potential, 12);
    dendrite = '0;
    load_cfg(3'd2, 0, 0, 0, 5'd0, 3'd1, 2'd0);
    chk("t3_cfg_holds_pot", potential, 12);
    chk("t3_cfg_axon", axon, 0);
    clockbus = 8'b0000_0010;
    step(); chk("t3_dec6", potential, 6);
    step(); chk("t3_dec3", potential, 3);
    step(); chk("t3_dec1", potential, 1);
    step(); chk("t3_dec0", potential, 0);
    step(); chk("t3_dec0b", potential, 0);
    clockbus = '0;
    dendrite = 4'b0001;
    repeat (6) step();
    chk("t3_rebuild12", potential, 12);
    clockbus = 8'b0000_0010;
    step(); chk("t3_halve_add8", potential, 8);
    clockbus = '0; dendrite = '0;

    // Chain: pattern in, pause, zeros in; bs_out replays pattern CFG_LEN later
    reset = 1'b1; step(); reset = 1'b0;
    pat = 22'h25A5A5;
    config_en = 1'b1;
    for (int i = 0; i < CFG_LEN; i++) begin
      chk("t4_bs_out_pre", bs_out, 0);
      bs_in = pat[i];
      step();
    end
    config_en = 1'b0; bs_in = 1'b0;
    repeat (3) begin
      step(); chk("t4_hold", bs_out, pat[0]);
    end
    config_en = 1'b1;
    for (int i = 0; i < CFG_LEN; i++) begin
      chk($sformatf("t4_replay%0d", i), bs_out, pat[i]);
      step();
    end
    config_en = 1'b0;
    chk("t4_drained", bs_out, 0);

    // reset_nn during refractory returns to INTEG; config intact
    load_cfg(3'd7, 0, 0, 0, 5'd5, 3'd0, 2'd3);
    nn_pulse();
    dendrite = 4'b0001;
    step(); chk("t5_fire", axon, 1);
    step(); chk("t5_refr_axon", axon, 0);
    reset_nn = 1'b1;
    step(); chk("t5_nn_pot", potential, 0); chk("t5_nn_axon", axon, 0);
    reset_nn = 1'b0;
    step(); chk("t5_refire", axon, 1);
    // Back-to-back fires with refrac_len 0
    load_cfg(3'd7, 0, 0, 0, 5'd5, 3'd0, 2'd0);
    nn_pulse();
    step(); chk("t5_b2b_1", axon, 1);
    step(); chk("t5_b2b_2", axon, 1);
    // Threshold 0 disables firing; potential saturates
    load_cfg(3'd7, 3'd7, 3'd7, 3'd7, 5'd0, 3'd0, 2'd0);
    nn_pulse();
    dendrite = 4'b1111;
    step(); chk("t5_dis_pot28", potential, 28); chk("t5_dis_ax1", axon, 0);
    step(); chk("t5_dis_sat", potential, 31); chk("t5_dis_ax2", axon, 0);
    step(); chk("t5_dis_sat2", potential, 31); chk("t5_dis_ax3", axon, 0);
    dendrite = '0;

`ifdef RETOSPECT_LIF_INHIB_EN
    load_cfg(3'd2, 3'b101, 0, 0, 5'd0, 3'd0, 2'd0);
    nn_pulse();
    dendrite = 4'b0001; step(); chk("t6_pot2", potential, 2);
    dendrite = 4'b0011; step(); chk("t6_pot1", potential, 1);
    dendrite = 4'b0010; step(); chk("t6_floor0", potential, 0);
    dendrite = 4'b0001; step(); chk("t6_pot2b", potential, 2);
    step(); chk("t6_pot4", potential, 4);
    dendrite = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
